cache_req_arbiter: RTL
======================

Name: cache_req_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the 4-way cache; owns the cache's addr/data/wr inputs.
- Serialises one access at a time and waits for the cache response, with a timeout.
- Returns read data and the hit/miss flag to the granted requester.
- Keeps saturating hit and miss counters, which feed the display and miss-rate logic.

Parameters:
ADDR_W, 32, width of request and cache address.
DATA_W, 32, width of write/read data.
TIMEOUT, 64, max cycles c_req stays high without c_response before abort (>=2).
CNT_W, 16, width of hit/miss counters.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
r0_req  in  1  requester 0 request, held until r0_ack
r0_wr  in  1  requester 0: 1=write, 0=read
r0_addr  in  ADDR_W  requester 0 address
r0_wdata  in  DATA_W  requester 0 write data
r0_ack  out  1  one-cycle completion pulse to requester 0
r0_err  out  1  valid with r0_ack: access timed out
r1_req, r1_wr, r1_addr, r1_wdata, r1_ack, r1_err  same as above for requester 1
rdata  out  DATA_W  read data, valid with either ack
rmiss  out  1  valid with either ack: access missed
c_req  out  1  cache access strobe, held until c_response
c_wr  out  1  to cache wr
c_addr  out  ADDR_W  to cache addr
c_data  out  DATA_W  to cache data
c_response  in  1  cache completion, one cycle
c_miss  in  1  cache is_missrate, valid with c_response
c_out  in  DATA_W  cache out, valid with c_response
clr_stats  in  1  synchronous clear of counters
hit_cnt  out  CNT_W  saturating hit count
miss_cnt  out  CNT_W  saturating miss count
busy  out  1  high when state != IDLE

Behaviour:
- Reset: all outputs 0; state IDLE; last_gnt=1, so r0 wins the first contention.
  - Reset mid-access drops c_req immediately and issues no ack.
  - A stale c_response arriving after reset is ignored.
- All outputs are registered.
- States: IDLE, WAIT, ACK.
- IDLE:
  - Only one request: grant it.
  - Both requesting: grant the requester that is not last_gnt.
  - On grant: latch wr/addr/wdata into c_wr/c_addr/c_data, set c_req=1, last_gnt=granted, go to WAIT.
  - c_response is ignored in IDLE.
- WAIT:
  - c_addr/c_data/c_wr stay stable while c_req=1.
  - Timeout counter starts at 0 on entry and increments each WAIT cycle.
  - On c_response=1:
    - c_req=0; rdata=c_out; rmiss=c_miss.
    - Increment hit_cnt if c_miss=0, else miss_cnt; both saturate at all-ones.
    - Assert the granted ack with err=0; go to ACK.
  - Else, if the counter reaches TIMEOUT-1:
    - c_req=0; rdata=0; rmiss=0; counters unchanged.
    - Assert the granted ack with err=1; go to ACK.
  - If c_response and the timeout occur in the same cycle, c_response wins.
- ACK:
  - ack/err are high for exactly this cycle; next state IDLE.
  - rdata/rmiss hold their values until the next ack.
- Requester protocol:
  - The requester keeps req and its fields stable until it samples ack.
  - It deasserts req in the cycle after ack.
  - req still high in IDLE after ACK is treated as a new request.
  - Field changes while req is high and not yet granted are allowed; values are sampled at grant.
- Latency:
  - req high in cycle 0 (IDLE) gives c_req high in cycle 1.
  - c_response in cycle k gives ack in cycle k+1 and IDLE in cycle k+2.
  - Minimum request-to-ack is 2 cycles; back-to-back grants are 3 cycles apart.
- clr_stats:
  - Sets both counters to 0 next cycle.
  - Wins over a simultaneous increment.
  - Does not affect an access in flight.

Test Plan:
- Single read: r0 read addr 0x05, cache responds 3 cycles after c_req with c_out=0x2, c_miss=1 -> c_addr=0x05, c_wr=0, r0_ack one cycle after c_response, rdata=0x2, rmiss=1, miss_cnt=1, hit_cnt=0.
- Contention: r0 and r1 both held high from reset, cache responds after 1 cycle with c_miss=0 -> grant order r0,r1,r0,r1, acks 3 cycles apart, hit_cnt=4 after 4 acks.
- Timeout: r1 write, c_response never asserted -> c_req high exactly TIMEOUT cycles, then r1_ack=1 with r1_err=1, rdata=0, counters unchanged.
- Same-cycle c_response and timeout (c_response on the last WAIT cycle) -> err=0, data taken from c_out, counter incremented.
- Saturation/clear: CNT_W=2, five hits -> hit_cnt=3. Then clr_stats asserted in the same cycle as a hit response -> hit_cnt=0.
- Async reset asserted mid-WAIT, then a c_response arrives after reset release -> c_req drops immediately, no ack, counters 0, busy=0, next contention grants r0.

Source files
------------

// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter and access sequencer for two requesters sharing the 4-way cache.
// Serialises one cache access at a time, aborts on timeout and keeps saturating hit/miss counts.
module cache_req_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              r0_req,
  input  logic              r0_wr,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ack,
  output logic              r0_err,

  input  logic              r1_req,
  input  logic              r1_wr,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ack,
  output logic              r1_err,

  output logic [DATA_W-1:0] rdata,
  output logic              rmiss,

  output logic              c_req,
  output logic              c_wr,
  output logic [ADDR_W-1:0] c_addr,
  output logic [DATA_W-1:0] c_data,
  input  logic              c_response,
  input  logic              c_miss,
  input  logic [DATA_W-1:0] c_out,

  input  logic              clr_stats,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt,
  output logic              busy
);

  localparam int                TMO_W    = $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } state_t;

  state_t             state, state_nxt;
  logic               last_gnt, last_gnt_nxt;
  logic               gnt, gnt_nxt;
  logic [TMO_W-1:0]   tmo_cnt, tmo_nxt;

  logic               c_req_nxt;
  logic               c_wr_nxt;
  logic [ADDR_W-1:0]  c_addr_nxt;
  logic [DATA_W-1:0]  c_data_nxt;
  logic               r0_ack_nxt, r0_err_nxt;
  logic               r1_ack_nxt, r1_err_nxt;
  logic [DATA_W-1:0]  rdata_nxt;
  logic               rmiss_nxt;
  logic [CNT_W-1:0]   hit_nxt, miss_nxt;
  logic               busy_nxt;

  logic               pick;
  logic               done;
  logic               timed_out;

  // Requester 1 is picked when it asks alone, or when both ask and r0 was served last.
  assign pick = (r0_req && r1_req) ? ~last_gnt : ~r0_req;

  // NOTE: every variable driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt    = state;
    last_gnt_nxt = last_gnt;
    gnt_nxt      = gnt;
    tmo_nxt      = tmo_cnt;
    c_req_nxt    = c_req;
    c_wr_nxt     = c_wr;
    c_addr_nxt   = c_addr;
    c_data_nxt   = c_data;
    r0_ack_nxt   = 1'b0;
    r0_err_nxt   = 1'b0;
    r1_ack_nxt   = 1'b0;
    r1_err_nxt   = 1'b0;
    rdata_nxt    = rdata;
    rmiss_nxt    = rmiss;
    hit_nxt      = hit_cnt;
    miss_nxt     = miss_cnt;
    done         = 1'b0;
    timed_out    = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (r0_req || r1_req) begin
          gnt_nxt      = pick;
          last_gnt_nxt = pick;
          c_req_nxt    = 1'b1;
          c_wr_nxt     = pick ? r1_wr    : r0_wr;
          c_addr_nxt   = pick ? r1_addr  : r0_addr;
          c_data_nxt   = pick ? r1_wdata : r0_wdata;
          tmo_nxt      = '0;
          state_nxt    = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // A response on the final allowed cycle still counts as a completion.
        if (c_response) begin
          done      = 1'b1;
          rdata_nxt = c_out;
          rmiss_nxt = c_miss;
          if (c_miss) begin
            miss_nxt = (miss_cnt == CNT_MAX) ? miss_cnt : miss_cnt + 1'b1;
          end else begin
            hit_nxt  = (hit_cnt == CNT_MAX) ? hit_cnt : hit_cnt + 1'b1;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          done      = 1'b1;
          timed_out = 1'b1;
          rdata_nxt = '0;
          rmiss_nxt = 1'b0;
        end else begin
          tmo_nxt   = tmo_cnt + 1'b1;
        end

        if (done) begin
          c_req_nxt  = 1'b0;
          r0_ack_nxt = ~gnt;
          r1_ack_nxt = gnt;
          r0_err_nxt = ~gnt & timed_out;
          r1_err_nxt = gnt & timed_out;
          state_nxt  = ST_ACK;
        end
      end

      ST_ACK: begin
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
        c_req_nxt = 1'b0;
      end
    endcase

    // Clearing takes priority over an increment landing in the same cycle.
    if (clr_stats) begin
      hit_nxt  = '0;
      miss_nxt = '0;
    end

    busy_nxt = (state_nxt != ST_IDLE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values computed above from the same clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      last_gnt <= 1'b1;
      gnt      <= 1'b0;
      tmo_cnt  <= '0;
      c_req    <= 1'b0;
      c_wr     <= 1'b0;
      c_addr   <= '0;
      c_data   <= '0;
      r0_ack   <= 1'b0;
      r0_err   <= 1'b0;
      r1_ack   <= 1'b0;
      r1_err   <= 1'b0;
      rdata    <= '0;
      rmiss    <= 1'b0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      last_gnt <= last_gnt_nxt;
      gnt      <= gnt_nxt;
      tmo_cnt  <= tmo_nxt;
      c_req    <= c_req_nxt;
      c_wr     <= c_wr_nxt;
      c_addr   <= c_addr_nxt;
      c_data   <= c_data_nxt;
      r0_ack   <= r0_ack_nxt;
      r0_err   <= r0_err_nxt;
      r1_ack   <= r1_ack_nxt;
      r1_err   <= r1_err_nxt;
      rdata    <= rdata_nxt;
      rmiss    <= rmiss_nxt;
      hit_cnt  <= hit_nxt;
      miss_cnt <= miss_nxt;
      busy     <= busy_nxt;
    end
  end

endmodule
